dio_test_sequencer: RTL and testbench

- Sequences the DIO loopback tester through a sweep of clock-divider values for one host-selected mode.
- For each divider step it configures the tester, waits a settle window that scales with the divider, and accumulates the tester's sticky status over a dwell window.
- After each step it emits one result word; after the last step it turns the tester off.
- It sits between the host command stream (MicroBlaze AXI-Stream FIFO) and the tester's dio_settings / dio_counter_status streams.

---
 rtl/dio_test_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_dio_test_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dio_test_sequencer.sv
// Sweeps the DIO loopback tester across a range of clock dividers for one mode.
// Each step: configure, settle, accumulate sticky status over a dwell window, and report one result word.
module dio_test_sequencer #(
    parameter int SETTLE_BASE    = 16,
    parameter int SETTLE_PERIODS = 4,
    parameter int DWELL_CYCLES   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_tdata,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    input  logic        abort,
    output logic [31:0] dio_settings_tdata,
    output logic        dio_settings_tvalid,
    input  logic        dio_settings_tready,
    input  logic [31:0] dio_counter_status_tdata,
    input  logic        dio_counter_status_tvalid,
    output logic        dio_counter_status_tready,
    output logic [47:0] result_tdata,
    output logic        result_tvalid,
    input  logic        result_tready,
    output logic        busy,
    output logic        done
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_SETTLE,
        S_DWELL,
        S_REPORT,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [7:0]    div_end_q, div_end_d;
    logic [7:0]    phase_q, phase_d;
    logic [1:0]    mode_q, mode_d;
    logic          abort_pend_q, abort_pend_d;
    logic          reject_q, reject_d;
    logic [15:0]   err_mask_q, err_mask_d;
    logic [15:0]   err_cycles_q, err_cycles_d;
    logic          nr_seen_q, nr_seen_d;
    logic          pb_seen_q, pb_seen_d;
    logic [15:0]   settle_cnt_q, settle_cnt_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;

    logic          cmd_tready_q, cmd_tready_d;
    logic          set_tvalid_q, set_tvalid_d;
    logic [31:0]   set_tdata_q, set_tdata_d;
    logic          stat_tready_q, stat_tready_d;
    logic          res_tvalid_q, res_tvalid_d;
    logic [47:0]   res_tdata_q, res_tdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          cmd_hs, set_hs, stat_hs, res_hs;
    logic          abort_now, last_q, last_d;
    logic [15:0]   settle_load;

    logic          unused_bits;
    assign unused_bits = ^{cmd_tdata[31:26], dio_counter_status_tdata[31:18]};

    assign cmd_hs      = cmd_tvalid & cmd_tready_q;
    assign set_hs      = set_tvalid_q & dio_settings_tready;
    assign stat_hs     = dio_counter_status_tvalid & stat_tready_q;
    assign res_hs      = res_tvalid_q & result_tready;
    assign abort_now   = abort_pend_q | abort;
    assign last_q      = reject_q | abort_pend_q | (div_q == div_end_q);
    assign settle_load = 16'(SETTLE_BASE) + 16'(SETTLE_PERIODS) * (16'(div_q) + 16'd1);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        div_end_d    = div_end_q;
        phase_d      = phase_q;
        mode_d       = mode_q;
        abort_pend_d = abort_pend_q;
        reject_d     = reject_q;
        err_mask_d   = err_mask_q;
        err_cycles_d = err_cycles_q;
        nr_seen_d    = nr_seen_q;
        pb_seen_d    = pb_seen_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;

        if (state_q != S_IDLE && abort) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    div_d        = cmd_tdata[7:0];
                    div_end_d    = cmd_tdata[15:8];
                    phase_d      = cmd_tdata[23:16];
                    mode_d       = cmd_tdata[25:24];
                    abort_pend_d = 1'b0;
                    err_mask_d   = '0;
                    err_cycles_d = '0;
                    nr_seen_d    = 1'b0;
                    pb_seen_d    = 1'b0;
                    if (cmd_tdata[25:24] == 2'd0 || cmd_tdata[7:0] > cmd_tdata[15:8]) begin
                        reject_d = 1'b1;
                        state_d  = S_REPORT;
                    end else begin
                        reject_d = 1'b0;
                        state_d  = S_CONFIG;
                    end
                end
            end
            S_CONFIG: begin
                if (set_hs) begin
                    err_mask_d   = '0;
                    err_cycles_d = '0;
                    nr_seen_d    = 1'b0;
                    pb_seen_d    = 1'b0;
                    settle_cnt_d = settle_load;
                    state_d      = abort_now ? S_REPORT : S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Status accepted here is dropped on purpose: it flushes stickies from the previous setting.
                if (abort_now) begin
                    state_d = S_REPORT;
                end else if (settle_cnt_q <= 16'd1) begin
                    dwell_cnt_d = DW'(DWELL_CYCLES);
                    state_d     = S_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q - 16'd1;
                end
            end
            S_DWELL: begin
                if (stat_hs) begin
                    err_mask_d = err_mask_q | dio_counter_status_tdata[15:0];
                    nr_seen_d  = nr_seen_q | dio_counter_status_tdata[16];
                    pb_seen_d  = pb_seen_q | dio_counter_status_tdata[17];
                    if (dio_counter_status_tdata[17:0] != 18'd0 && err_cycles_q != 16'hFFFF) begin
                        err_cycles_d = err_cycles_q + 16'd1;
                    end
                end
                if (abort_now || dwell_cnt_q <= DW'(1)) begin
                    state_d = S_REPORT;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DW'(1);
                end
            end
            S_REPORT: begin
                if (res_hs) begin
                    if (reject_q) begin
                        state_d = S_IDLE;
                    end else if (last_q) begin
                        state_d = S_STOP;
                    end else begin
                        div_d   = div_q + 8'd1;
                        state_d = S_CONFIG;
                    end
                end
            end
            S_STOP: begin
                if (set_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers are computed from the next state so every port comes straight from a flop.
    always_comb begin
        last_d        = reject_d | abort_pend_d | (div_d == div_end_d);
        cmd_tready_d  = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_q != S_IDLE) && (state_d == S_IDLE);
        set_tvalid_d  = (state_d == S_CONFIG) || (state_d == S_STOP);
        stat_tready_d = (state_d == S_SETTLE) || (state_d == S_DWELL);
        res_tvalid_d  = (state_d == S_REPORT);
        set_tdata_d   = set_tdata_q;
        res_tdata_d   = res_tdata_q;
        if (state_d == S_CONFIG) begin
            set_tdata_d = {14'd0, mode_d, phase_d, div_d};
        end else if (state_d == S_STOP) begin
            set_tdata_d = {14'd0, 2'd0, phase_d, div_d};
        end
        if (state_d == S_REPORT) begin
            res_tdata_d = {4'd0, reject_d, last_d, pb_seen_d, nr_seen_d, div_d,
                           err_cycles_d, err_mask_d};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            div_end_q     <= '0;
            phase_q       <= '0;
            mode_q        <= '0;
            abort_pend_q  <= 1'b0;
            reject_q      <= 1'b0;
            err_mask_q    <= '0;
            err_cycles_q  <= '0;
            nr_seen_q     <= 1'b0;
            pb_seen_q     <= 1'b0;
            settle_cnt_q  <= '0;
            dwell_cnt_q   <= '0;
            cmd_tready_q  <= 1'b1;
            set_tvalid_q  <= 1'b0;
            set_tdata_q   <= '0;
            stat_tready_q <= 1'b0;
            res_tvalid_q  <= 1'b0;
            res_tdata_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            div_end_q     <= div_end_d;
            phase_q       <= phase_d;
            mode_q        <= mode_d;
            abort_pend_q  <= abort_pend_d;
            reject_q      <= reject_d;
            err_mask_q    <= err_mask_d;
            err_cycles_q  <= err_cycles_d;
            nr_seen_q     <= nr_seen_d;
            pb_seen_q     <= pb_seen_d;
            settle_cnt_q  <= settle_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
            cmd_tready_q  <= cmd_tready_d;
            set_tvalid_q  <= set_tvalid_d;
            set_tdata_q   <= set_tdata_d;
            stat_tready_q <= stat_tready_d;
            res_tvalid_q  <= res_tvalid_d;
            res_tdata_q   <= res_tdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign cmd_tready                = cmd_tready_q;
    assign dio_settings_tvalid       = set_tvalid_q;
    assign dio_settings_tdata        = set_tdata_q;
    assign dio_counter_status_tready = stat_tready_q;
    assign result_tvalid             = res_tvalid_q;
    assign result_tdata              = res_tdata_q;
    assign busy                      = busy_q;
    assign done                      = done_q;

endmodule

// File: tb/tb_dio_test_sequencer.sv
// Directed bench for dio_test_sequencer: sweeps, faults, rejects, backpressure, abort and reset boundaries.
module tb_dio_test_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic        abort;
    logic [31:0] set_tdata;
    logic        set_tvalid;
    logic        set_tready;
    logic [31:0] stat_tdata;
    logic        stat_tvalid;
    logic        stat_tready;
    logic [47:0] res_tdata;
    logic        res_tvalid;
    logic        res_tready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] set_q[$];
    logic [47:0] res_q[$];
    bit bp_active = 0;

    dio_test_sequencer #(
        .SETTLE_BASE(16),
        .SETTLE_PERIODS(4),
        .DWELL_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_tdata(cmd_tdata),
        .cmd_tvalid(cmd_tvalid),
        .cmd_tready(cmd_tready),
        .abort(abort),
        .dio_settings_tdata(set_tdata),
        .dio_settings_tvalid(set_tvalid),
        .dio_settings_tready(set_tready),
        .dio_counter_status_tdata(stat_tdata),
        .dio_counter_status_tvalid(stat_tvalid),
        .dio_counter_status_tready(stat_tready),
        .result_tdata(res_tdata),
        .result_tvalid(res_tvalid),
        .result_tready(res_tready),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (set_tvalid && set_tready) set_q.push_back(set_tdata);
            if (res_tvalid && res_tready) res_q.push_back(res_tdata);
            if (done) done_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [31:0] data, output bit ok);
        int n = 0;
        @(posedge clk); #1;
        cmd_tdata  = data;
        cmd_tvalid = 1'b1;
        ok = 1'b0;
        while (n < 3000) begin
            @(negedge clk);
            if (cmd_tready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        @(posedge clk); #1;
        cmd_tvalid = 1'b0;
    endtask

    task automatic wait_set(input int target, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 3000) begin
            @(negedge clk); #1;
            if (set_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    task automatic wait_done(input int base, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 8000) begin
            @(negedge clk); #1;
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (set_tvalid !== 1'b0 || res_tvalid !== 1'b0 || stat_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got set=%b res=%b stat_rdy=%b want 0 0 0", set_tvalid, res_tvalid, stat_tready);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b cmd_rdy=%b want 0 0 1", busy, done, cmd_tready);
        end
        checks++;
        if (set_tdata !== 32'd0 || res_tdata !== 48'd0) begin
            errors++;
            $display("FAIL reset_data got set=%h res=%h want 0 0", set_tdata, res_tdata);
        end
    endtask

    task automatic test_clean();
        int sb = set_q.size();
        int rb = res_q.size();
        int db = done_cnt;
        bit ok;
        logic [31:0] es[4] = '{32'h00020103, 32'h00020104, 32'h00020105, 32'h00000105};
        logic [47:0] er[3] = '{48'h000300000000, 48'h000400000000, 48'h040500000000};
        send_cmd(32'h02010503, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clean_cmd got no accept want accept"); end
        wait_done(db, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clean_done got timeout want done"); end
        repeat (3) @(posedge clk);
        checks++;
        if (done_cnt != db + 1) begin errors++; $display("FAIL clean_done_cnt got %0d want %0d", done_cnt - db, 1); end
        checks++;
        if (set_q.size() != sb + 4) begin
            errors++;
            $display("FAIL clean_set_count got %0d want 4", set_q.size() - sb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (set_q[sb+i] !== es[i]) begin errors++; $display("FAIL clean_set%0d got %h want %h", i, set_q[sb+i], es[i]); end
            end
        end
        checks++;
        if (res_q.size() != rb + 3) begin
            errors++;
            $display("FAIL clean_res_count got %0d want 3", res_q.size() - rb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (res_q[rb+i] !== er[i]) begin errors++; $display("FAIL clean_res%0d got %h want %h", i, res_q[rb+i], er[i]); end
            end
        end
    endtask

    task automatic test_fault();
        int sb = set_q.size();
        int rb = res_q.size();
        int db = done_cnt;
        bit ok;
        send_cmd(32'h01000303, ok);
        wait_set(sb + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fault_config got timeout want settings"); end
        @(posedge clk);
        // SETTLE spans 32 cycles after the settings edge; DWELL the following 64.
        for (int k = 0; k < 60; k++) begin
            #1;
            stat_tdata = ((k >= 4 && k <= 9) || (k >= 39 && k <= 43)) ? 32'h00000010 : 32'h0;
            @(posedge clk);
        end
        #1 stat_tdata = 32'h0;
        wait_done(db, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fault_done got timeout want done"); end
        checks++;
        if (res_q.size() != rb + 1 || res_q[rb] !== 48'h040300050010) begin
            errors++;
            $display("FAIL fault_result got n=%0d %h want 1 %h", res_q.size() - rb, res_q[rb], 48'h040300050010);
        end
        checks++;
        if (set_q.size() != sb + 2 || set_q[sb+1] !== 32'h00000003) begin
            errors++;
            $display("FAIL fault_stop got n=%0d %h want 2 %h", set_q.size() - sb, set_q[sb+1], 32'h00000003);
        end
    endtask

    task automatic test_reject();
        logic [31:0] cmds[2] = '{32'h00000402, 32'h01000209};
        logic [47:0] er[2]   = '{48'h0C0200000000, 48'h0C0900000000};
        for (int i = 0; i < 2; i++) begin
            int sb = set_q.size();
            int rb = res_q.size();
            int db = done_cnt;
            bit ok;
            send_cmd(cmds[i], ok);
            wait_done(db, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL reject%0d_done got timeout want done", i); end
            repeat (3) @(posedge clk);
            checks++;
            if (res_q.size() != rb + 1 || res_q[rb] !== er[i]) begin
                errors++;
                $display("FAIL reject%0d_result got n=%0d %h want 1 %h", i, res_q.size() - rb, res_q[rb], er[i]);
            end
            checks++;
            if (set_q.size() != sb) begin errors++; $display("FAIL reject%0d_settings got %0d words want 0", i, set_q.size() - sb); end
        end
    endtask

    task automatic test_back_to_back();
        int sb = set_q.size();
        int rb = res_q.size();
        int db = done_cnt;
        bit ok;
        logic [31:0] es[3] = '{32'h00015501, 32'h00015502, 32'h00005502};
        logic [47:0] er[2] = '{48'h000100000000, 48'h040200000000};
        res_tready = 1'b0;
        bp_active  = 1'b1;
        fork
            while (bp_active) begin
                @(posedge clk); #1;
                set_tready = ~set_tready;
            end
        join_none
        send_cmd(32'h01550201, ok);
        for (int r = 0; r < 2; r++) begin
            logic [47:0] snap;
            bit stable = 1'b1;
            bit srdy_ok = 1'b1;
            int n = 0;
            while (!res_tvalid && n < 3000) begin @(negedge clk); n++; end
            checks++;
            if (!res_tvalid) begin errors++; $display("FAIL bp_res%0d_valid got timeout want valid", r); end
            snap = res_tdata;
            repeat (20) begin
                @(negedge clk);
                if (res_tdata !== snap || res_tvalid !== 1'b1) stable = 1'b0;
                if (stat_tready !== 1'b0) srdy_ok = 1'b0;
            end
            checks++;
            if (!stable) begin errors++; $display("FAIL bp_res%0d_stable got %h want %h", r, res_tdata, snap); end
            checks++;
            if (!srdy_ok) begin errors++; $display("FAIL bp_res%0d_stat_ready got 1 want 0", r); end
            @(posedge clk); #1 res_tready = 1'b1;
            @(posedge clk); #1 res_tready = 1'b0;
        end
        bp_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_tready = 1'b1;
        res_tready = 1'b1;
        wait_done(db, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done got timeout want done"); end
        checks++;
        if (set_q.size() != sb + 3) begin
            errors++;
            $display("FAIL bp_set_count got %0d want 3", set_q.size() - sb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (set_q[sb+i] !== es[i]) begin errors++; $display("FAIL bp_set%0d got %h want %h", i, set_q[sb+i], es[i]); end
            end
        end
        checks++;
        if (res_q.size() != rb + 2) begin
            errors++;
            $display("FAIL bp_res_count got %0d want 2", res_q.size() - rb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (res_q[rb+i] !== er[i]) begin errors++; $display("FAIL bp_res%0d got %h want %h", i, res_q[rb+i], er[i]); end
            end
        end
    endtask

    task automatic test_abort();
        int sb = set_q.size();
        int rb = res_q.size();
        int db = done_cnt;
        bit ok;
        send_cmd(32'h01000803, ok);
        wait_set(sb + 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_step2 got timeout want settings"); end
        @(posedge clk);
        // div=4 settles for 36 cycles, so 50 cycles in lands inside DWELL.
        repeat (50) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(db, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_done got timeout want done"); end
        checks++;
        if (res_q.size() != rb + 2 || res_q[rb+1] !== 48'h040400000000) begin
            errors++;
            $display("FAIL abort_result got n=%0d %h want 2 %h", res_q.size() - rb, res_q[rb+1], 48'h040400000000);
        end
        checks++;
        if (set_q.size() != sb + 3 || set_q[sb+2] !== 32'h00000004) begin
            errors++;
            $display("FAIL abort_stop got n=%0d %h want 3 %h", set_q.size() - sb, set_q[sb+2], 32'h00000004);
        end
    endtask

    task automatic test_div_255();
        int sb = set_q.size();
        int rb = res_q.size();
        int db = done_cnt;
        bit ok;
        send_cmd(32'h03AAFFFF, ok);
        wait_done(db, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL d255_done got timeout want done"); end
        checks++;
        if (set_q.size() != sb + 2 || set_q[sb] !== 32'h0003AAFF || set_q[sb+1] !== 32'h0000AAFF) begin
            errors++;
            $display("FAIL d255_settings got n=%0d %h %h want 2 0003aaff 0000aaff", set_q.size() - sb, set_q[sb], set_q[sb+1]);
        end
        checks++;
        if (res_q.size() != rb + 1 || res_q[rb] !== 48'h04FF00000000) begin
            errors++;
            $display("FAIL d255_result got n=%0d %h want 1 %h", res_q.size() - rb, res_q[rb], 48'h04FF00000000);
        end
    endtask

    task automatic test_reset_mid();
        int sb = set_q.size();
        int rb;
        int db;
        bit ok;
        send_cmd(32'h02030C0A, ok);
        wait_set(sb + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_config got timeout want settings"); end
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (stat_tready !== 1'b0 || busy !== 1'b0 || set_tvalid !== 1'b0 || res_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got stat_rdy=%b busy=%b set_v=%b res_v=%b want 0 0 0 0", stat_tready, busy, set_tvalid, res_tvalid);
        end
        checks++;
        if (set_tdata !== 32'd0 || cmd_tready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_values got set=%h cmd_rdy=%b done=%b want 0 1 0", set_tdata, cmd_tready, done);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        sb = set_q.size();
        rb = res_q.size();
        db = done_cnt;
        repeat (20) @(posedge clk);
        checks++;
        if (set_q.size() != sb || res_q.size() != rb || done_cnt != db) begin
            errors++;
            $display("FAIL rmid_quiet got set=%0d res=%0d done=%0d want 0 0 0", set_q.size() - sb, res_q.size() - rb, done_cnt - db);
        end
        send_cmd(32'h01000707, ok);
        wait_done(db, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_rerun got timeout want done"); end
        checks++;
        if (set_q.size() != sb + 2 || set_q[sb] !== 32'h00010007 || set_q[sb+1] !== 32'h00000007) begin
            errors++;
            $display("FAIL rmid_rerun_set got n=%0d %h %h want 2 00010007 00000007", set_q.size() - sb, set_q[sb], set_q[sb+1]);
        end
        checks++;
        if (res_q.size() != rb + 1 || res_q[rb] !== 48'h040700000000) begin
            errors++;
            $display("FAIL rmid_rerun_res got n=%0d %h want 1 %h", res_q.size() - rb, res_q[rb], 48'h040700000000);
        end
    endtask

    initial begin
        reset       = 1'b1;
        cmd_tdata   = 32'h0;
        cmd_tvalid  = 1'b0;
        abort       = 1'b0;
        set_tready  = 1'b1;
        stat_tdata  = 32'h0;
        stat_tvalid = 1'b1;
        res_tready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        test_clean();
        test_fault();
        test_reject();
        test_back_to_back();
        test_abort();
        test_div_255();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
